// File: rtl/sec_counter_3disp_if.sv
// Bus bundle for sec_counter_3disp: tick/enable/clear controls in, BCD count,
// wrap pulse and multiplexed 7-segment drive out.
interface sec_counter_3disp_if;
  logic        tick;
  logic        en;
  logic        clear;
  logic [11:0] count_bcd;
  logic        wrap;
  logic [2:0]  an;
  logic [6:0]  seg;

  // Driver side: stimulus/controller feeding the counter.
  modport master (
    output tick, en, clear,
    input  count_bcd, wrap, an, seg
  );

  // Counter side.
  modport slave (
    input  tick, en, clear,
    output count_bcd, wrap, an, seg
  );
endinterface

// File: rtl/sec_counter_3disp.sv
// Seconds counter 000-999 (BCD) with time-multiplexed common-anode 7-segment
// drive for three digits. Optional macro LEADING_ZERO_BLANK_EN blanks leading
// zeros on the hundreds and tens digits.
module sec_counter_3disp #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned SCAN_W   = 17
) (
  input  logic              clk,
  input  logic              rst,
  sec_counter_3disp_if.slave bus
);

  localparam int unsigned DIG_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 3;

  typedef enum logic [1:0] {
    DIG_UNITS = 2'd0,
    DIG_TENS  = 2'd1,
    DIG_HUNDS = 2'd2,
    DIG_BAD   = 2'd3
  } digit_e;

  logic [DIG_W-1:0]  units_q, units_d;
  logic [DIG_W-1:0]  tens_q,  tens_d;
  logic [DIG_W-1:0]  hunds_q, hunds_d;
  logic              wrap_q,  wrap_d;
  logic [SCAN_W-1:0] scan_q,  scan_d;
  digit_e            dig_q,   dig_d;
  logic [AN_W-1:0]   an_q,    an_d;
  logic [SEG_W-1:0]  seg_q,   seg_d;
  logic              scan_last_c;

  // BCD digit to active-low gfedcba pattern; non-decimal codes go dark.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [DIG_W-1:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Count next-state: clear wins over an enabled tick; wrap only on 999->000 by increment.
  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    hunds_d = hunds_q;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      units_d = '0;
      tens_d  = '0;
      hunds_d = '0;
    end else if (bus.tick && bus.en) begin
      if (units_q >= 4'd9) begin
        units_d = '0;
        if (tens_q >= 4'd9) begin
          tens_d = '0;
          if (hunds_q >= 4'd9) begin
            hunds_d = '0;
            wrap_d  = 1'b1;
          end else begin
            hunds_d = DIG_W'(hunds_q + 4'd1);
          end
        end else begin
          tens_d = DIG_W'(tens_q + 4'd1);
        end
      end else begin
        units_d = DIG_W'(units_q + 4'd1);
      end
    end
  end

  // Free-running scan divider, one digit slot per SCAN_DIV cycles.
  assign scan_last_c = (scan_q == SCAN_W'(SCAN_DIV - 1));

  always_comb begin
    scan_d = scan_last_c ? '0 : SCAN_W'(scan_q + SCAN_W'(1));
  end

  // Digit-select FSM next state plus registered anode/segment values for the current slot.
  always_comb begin
    dig_d = dig_q;
    an_d  = 3'b111;
    seg_d = 7'b1111111;
    if (scan_last_c) begin
      case (dig_q)
        DIG_UNITS: dig_d = DIG_TENS;
        DIG_TENS:  dig_d = DIG_HUNDS;
        default:   dig_d = DIG_UNITS;
      endcase
    end
    case (dig_q)
      DIG_UNITS: begin
        an_d  = 3'b110;
        seg_d = seg_decode(units_q);
      end
      DIG_TENS: begin
        an_d  = 3'b101;
`ifdef LEADING_ZERO_BLANK_EN
        seg_d = (hunds_q == '0 && tens_q == '0) ? 7'b1111111 : seg_decode(tens_q);
`else
        seg_d = seg_decode(tens_q);
`endif
      end
      DIG_HUNDS: begin
        an_d  = 3'b011;
`ifdef LEADING_ZERO_BLANK_EN
        seg_d = (hunds_q == '0) ? 7'b1111111 : seg_decode(hunds_q);
`else
        seg_d = seg_decode(hunds_q);
`endif
      end
      default: begin
        an_d  = 3'b111;
        seg_d = 7'b1111111;
      end
    endcase
  end

  // State and output registers; reset blanks the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      units_q <= '0;
      tens_q  <= '0;
      hunds_q <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      dig_q   <= DIG_UNITS;
      an_q    <= 3'b111;
      seg_q   <= 7'b1111111;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
      hunds_q <= hunds_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.count_bcd = {hunds_q, tens_q, units_q};
  assign bus.wrap      = wrap_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;

endmodule
